spi_ram_arbiter: RTL and testbench

//   Shares the single-port RAM between the SPI slave command stream and a local host port.
//   The RAM takes 10-bit commands {op[1:0],payload[7:0]}:
//     00 = load write address, 01 = write data, 10 = load read address, 11 = read data.
//   The RAM holds its write/read address registers between commands. The arbiter therefore

---
 rtl/spi_ram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares a single-port command-driven RAM between the SPI slave command
//   stream and a local host port. The RAM takes {op[1:0], payload} commands:
//   00 load write address, 01 write data, 10 load read address, 11 read data.
//   The RAM keeps its address registers between commands, so after every host
//   access the arbiter re-issues the SPI-side address the host clobbered.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     spi_rx_data/spi_rx_valid      command word from SPI slave (1-cycle pulse)
//     spi_tx_data/spi_tx_valid      read data back to SPI slave (1-cycle pulse)
//     host_req/we/addr/wdata        host request, held until host_ack
//     host_ack/host_rdata/host_err  host completion pulse, read data, timeout flag
//     ram_din/ram_rx_valid          command to RAM, one cycle per command
//     ram_dout/ram_tx_valid         RAM read data
//     spi_ovf                       sticky: SPI word dropped because queue was full
module spi_ram_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_SIZE+1:0]   spi_rx_data,
    input  logic                   spi_rx_valid,
    output logic [ADDR_SIZE-1:0]   spi_tx_data,
    output logic                   spi_tx_valid,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [ADDR_SIZE-1:0]   host_addr,
    input  logic [ADDR_SIZE-1:0]   host_wdata,
    output logic                   host_ack,
    output logic [ADDR_SIZE-1:0]   host_rdata,
    output logic                   host_err,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid,
    output logic                   spi_ovf
);

    localparam int CW = ADDR_SIZE + 2;
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SPI_ISSUE, SPI_RD_WAIT, HOST_ADDR, HOST_DATA, HOST_RD_WAIT, RESTORE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          q_mem [2];
    logic                   q_wr, q_rd;
    logic [1:0]             q_cnt;
    logic                   q_push, q_pop;
    logic [CW-1:0]          q_head;
    logic [1:0]             last_op;
    logic                   h_we;
    logic [ADDR_SIZE-1:0]   wa_sh, ra_sh;
    logic                   wa_ok, ra_ok;
    logic [TW-1:0]          timer;
    logic                   timed_out;

    // The queue pops exactly when IDLE dispatches an SPI word, so a full
    // queue can still accept a word in that same cycle.
    always_comb begin
        q_head    = q_mem[q_rd];
        q_pop     = (state == IDLE) && (q_cnt != 2'd0);
        q_push    = spi_rx_valid && ((q_cnt != 2'd2) || q_pop);
        timed_out = (timer >= TW'(RD_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (q_push) q_mem[q_wr] <= spi_rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr    <= 1'b0;
            q_rd    <= 1'b0;
            q_cnt   <= 2'd0;
            spi_ovf <= 1'b0;
        end else begin
            if (q_push) q_wr <= ~q_wr;
            if (q_pop)  q_rd <= ~q_rd;
            case ({q_push, q_pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase
            if (spi_rx_valid && !q_push) spi_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            host_err     <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            last_op      <= 2'b00;
            h_we         <= 1'b0;
            wa_sh        <= '0;
            ra_sh        <= '0;
            wa_ok        <= 1'b0;
            ra_ok        <= 1'b0;
            timer        <= '0;
        end else begin
            ram_rx_valid <= 1'b0;
            spi_tx_valid <= 1'b0;
            host_ack     <= 1'b0;
            host_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (q_cnt != 2'd0) begin
                        // Command is registered here so it is on the RAM bus
                        // for the whole SPI_ISSUE cycle.
                        ram_din      <= q_head;
                        ram_rx_valid <= 1'b1;
                        last_op      <= q_head[CW-1:CW-2];
                        if (q_head[CW-1:CW-2] == 2'b00) begin
                            wa_sh <= q_head[ADDR_SIZE-1:0];
                            wa_ok <= 1'b1;
                        end
                        if (q_head[CW-1:CW-2] == 2'b10) begin
                            ra_sh <= q_head[ADDR_SIZE-1:0];
                            ra_ok <= 1'b1;
                        end
                        state <= SPI_ISSUE;
                    end else if (host_req && !spi_rx_valid) begin
                        // A word arriving this cycle lands in the queue next
                        // cycle; holding off the host keeps SPI priority.
                        h_we         <= host_we;
                        ram_din      <= {(host_we ? 2'b00 : 2'b10), host_addr};
                        ram_rx_valid <= 1'b1;
                        state        <= HOST_ADDR;
                    end
                end
                SPI_ISSUE: begin
                    timer <= TW'(1);
                    state <= (last_op == 2'b11) ? SPI_RD_WAIT : IDLE;
                end
                SPI_RD_WAIT: begin
                    if (ram_tx_valid) begin
                        spi_tx_data  <= ram_dout;
                        spi_tx_valid <= 1'b1;
                        state        <= IDLE;
                    end else if (timed_out) begin
                        state <= IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                HOST_ADDR: begin
                    ram_din      <= {(h_we ? 2'b01 : 2'b11), (h_we ? host_wdata : '0)};
                    ram_rx_valid <= 1'b1;
                    state        <= HOST_DATA;
                end
                HOST_DATA: begin
                    timer <= TW'(1);
                    if (h_we) begin
                        host_ack <= 1'b1;
                        state    <= RESTORE;
                    end else begin
                        state <= HOST_RD_WAIT;
                    end
                end
                HOST_RD_WAIT: begin
                    if (ram_tx_valid) begin
                        host_rdata <= ram_dout;
                        host_ack   <= 1'b1;
                        state      <= RESTORE;
                    end else if (timed_out) begin
                        host_rdata <= '0;
                        host_ack   <= 1'b1;
                        host_err   <= 1'b1;
                        state      <= RESTORE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                RESTORE: begin
                    if (h_we && wa_ok) begin
                        ram_din      <= {2'b00, wa_sh};
                        ram_rx_valid <= 1'b1;
                    end else if (!h_we && ra_ok) begin
                        ram_din      <= {2'b10, ra_sh};
                        ram_rx_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with scoreboards for RAM commands,
// SPI read returns and host completions, plus a simple RAM read responder.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_err;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       spi_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rd;
        logic       err;
        logic [7:0] data;
    } ack_t;

    logic [9:0] exp_ram[$];
    logic [7:0] exp_spi[$];
    ack_t       exp_ack[$];

    int         rsp_delay = 0;
    logic [7:0] rsp_data  = 8'h00;
    int         rsp_cnt   = 0;

    spi_ram_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_err(host_err), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .spi_ovf(spi_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM responder: answers a read-data command rsp_delay cycles later
    // (rsp_delay == 0 means the RAM never answers).
    always @(negedge clk) begin
        ram_tx_valid = 1'b0;
        if (rsp_cnt == 1) begin
            ram_tx_valid = 1'b1;
            ram_dout     = rsp_data;
        end
        if (rsp_cnt != 0) rsp_cnt--;
        if (ram_rx_valid && ram_din[9:8] == 2'b11 && rsp_delay != 0) rsp_cnt = rsp_delay;
    end

    // Output monitors feeding the scoreboards.
    always @(negedge clk) begin
        if (ram_rx_valid) begin
            if (exp_ram.size() == 0) begin
                checks++; errors++;
                $error("FAIL ram_unexpected observed=%0h expected=none", ram_din);
            end else begin
                check("ram_din", 32'(ram_din), 32'(exp_ram.pop_front()));
            end
        end
        if (spi_tx_valid) begin
            if (exp_spi.size() == 0) begin
                checks++; errors++;
                $error("FAIL spi_tx_unexpected observed=%0h expected=none", spi_tx_data);
            end else begin
                check("spi_tx_data", 32'(spi_tx_data), 32'(exp_spi.pop_front()));
            end
        end
        if (host_ack) begin
            if (exp_ack.size() == 0) begin
                checks++; errors++;
                $error("FAIL host_ack_unexpected observed=1 expected=0");
            end else begin
                ack_t a;
                a = exp_ack.pop_front();
                check("host_err", 32'(host_err), 32'(a.err));
                if (a.rd) check("host_rdata", 32'(host_rdata), 32'(a.data));
            end
        end
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_spi_tx_data"},  32'(spi_tx_data), 32'h0);
        check({tag, "_spi_tx_valid"}, 32'(spi_tx_valid), 32'h0);
        check({tag, "_host_ack"},     32'(host_ack), 32'h0);
        check({tag, "_host_rdata"},   32'(host_rdata), 32'h0);
        check({tag, "_host_err"},     32'(host_err), 32'h0);
        check({tag, "_ram_din"},      32'(ram_din), 32'h0);
        check({tag, "_ram_rx_valid"}, 32'(ram_rx_valid), 32'h0);
        check({tag, "_spi_ovf"},      32'(spi_ovf), 32'h0);
    endtask

    task automatic spi_send(input logic [9:0] w);
        @(negedge clk);
        spi_rx_data  = w;
        spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int max_cycles);
        int n = 0;
        while (!host_ack && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!host_ack) begin
            checks++; errors++;
            $error("FAIL %s_ack_timeout observed=0 expected=1", tag);
        end
        host_req = 1'b0;
    endtask

    task automatic drained(input string tag);
        check({tag, "_ram_left"}, 32'(exp_ram.size()), 32'h0);
        check({tag, "_spi_left"}, 32'(exp_spi.size()), 32'h0);
        check({tag, "_ack_left"}, 32'(exp_ack.size()), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        spi_rx_data = '0; spi_rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        ram_dout = '0; ram_tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        outputs_zero("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        outputs_zero("idle");

        // 1: reset in the middle of a host read; no ack may follow
        rsp_delay = 0;
        exp_ram.push_back(10'h240);
        exp_ram.push_back(10'h300);
        host_we = 1'b0; host_addr = 8'h40; host_req = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; host_req = 1'b0;
        @(negedge clk);
        outputs_zero("t1_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        outputs_zero("t1_after");
        drained("t1");

        // 2: two SPI writes go straight through
        exp_ram.push_back(10'h0FA);
        exp_ram.push_back(10'h1AF);
        spi_send(10'h0FA);
        spi_send(10'h1AF);
        repeat (10) @(negedge clk);
        drained("t2");

        // 3: SPI read address + read data, RAM answers 2 cycles later
        rsp_delay = 2; rsp_data = 8'h6F;
        exp_ram.push_back(10'h2C3);
        exp_ram.push_back(10'h333);
        exp_spi.push_back(8'h6F);
        spi_send(10'h2C3);
        spi_send(10'h333);
        repeat (10) @(negedge clk);
        drained("t3");

        // 4: host write between SPI words; write address restored
        exp_ram.push_back(10'h055);
        exp_ram.push_back(10'h010);
        exp_ram.push_back(10'h1A5);
        exp_ram.push_back(10'h055);
        exp_ram.push_back(10'h177);
        exp_ack.push_back('{rd: 1'b0, err: 1'b0, data: 8'h00});
        spi_send(10'h055);
        repeat (4) @(negedge clk);
        host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5; host_req = 1'b1;
        @(negedge clk);
        spi_rx_data = 10'h177; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        wait_ack("t4", 20);
        repeat (10) @(negedge clk);
        drained("t4");

        // 5: host read and SPI word in the same cycle; SPI goes first
        rsp_delay = 2; rsp_data = 8'h5A;
        exp_ram.push_back(10'h2C3);
        exp_ram.push_back(10'h220);
        exp_ram.push_back(10'h300);
        exp_ram.push_back(10'h2C3);
        exp_ack.push_back('{rd: 1'b1, err: 1'b0, data: 8'h5A});
        @(negedge clk);
        host_we = 1'b0; host_addr = 8'h20; host_req = 1'b1;
        spi_rx_data = 10'h2C3; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        wait_ack("t5", 40);
        repeat (10) @(negedge clk);
        drained("t5");

        // 6: host read times out while three SPI words arrive; third dropped
        rsp_delay = 0;
        exp_ram.push_back(10'h230);
        exp_ram.push_back(10'h300);
        exp_ram.push_back(10'h2C3);
        exp_ram.push_back(10'h011);
        exp_ram.push_back(10'h122);
        exp_ack.push_back('{rd: 1'b1, err: 1'b1, data: 8'h00});
        host_we = 1'b0; host_addr = 8'h30; host_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_ovf_before", 32'(spi_ovf), 32'h0);
        spi_send(10'h011);
        spi_send(10'h122);
        spi_send(10'h033);
        @(negedge clk);
        check("t6_ovf_set", 32'(spi_ovf), 32'h1);
        wait_ack("t6", 40);
        repeat (15) @(negedge clk);
        drained("t6");
        check("t6_ovf_sticky", 32'(spi_ovf), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
